// File: rtl/wide_alu_seq.sv
// wide_alu_seq: 16-bit add/sub/shift sequenced as two 8-bit passes through an external shared ALU.
package wide_alu_pkg;
    localparam logic [3:0] KADD = 4'd0;
    localparam logic [3:0] KSUB = 4'd1;
    localparam logic [3:0] KLSH = 4'd2;
    localparam logic [3:0] KRSH = 4'd3;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LSH = 2'b10;
    localparam logic [1:0] OP_RSH = 2'b11;
endpackage

module wide_alu_seq
    import wide_alu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        CIN,
    input  logic        FLUSH,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RESULT,
    output logic        COUT,
    output logic        ZERO16,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [3:0]  ALU_OP,
    output logic        ALU_SC_IN,
    input  logic [7:0]  ALU_OUT,
    input  logic        ALU_SC_OUT
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, FIN} state_e;
    state_e state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [7:0] byte_q, byte_d, a_byte, b_byte;
    logic cin_q, cin_d, carry_q, carry_d, cout_q, cout_d, zero_q, zero_d;
    logic accept, passing, hi_sel;
    always_comb begin
        accept = START && !FLUSH && (state_q == IDLE || state_q == FIN);
        passing = state_q == PASS1 || state_q == PASS2;
        state_d = FLUSH ? IDLE : accept ? PASS1 : state_q == PASS1 ? PASS2 : state_q == PASS2 ? FIN : IDLE;
        op_d = accept ? OP : op_q;
        a_d = accept ? A : a_q;
        b_d = accept ? B : b_q;
        cin_d = accept ? CIN : cin_q;
        // RSH walks high byte first so the carry shifts down into the low byte
        hi_sel = (state_q == PASS2) ^ (op_q == OP_RSH);
        a_byte = hi_sel ? a_q[15:8] : a_q[7:0];
        b_byte = hi_sel ? b_q[15:8] : b_q[7:0];
        ALU_OP = !passing ? KADD : op_q == OP_LSH ? KLSH : op_q == OP_RSH ? KRSH : KADD;
        ALU_A = passing ? a_byte : 8'h00;
        ALU_B = !passing ? 8'h00 : op_q == OP_ADD ? b_byte : op_q == OP_SUB ? ~b_byte : 8'h00;
        ALU_SC_IN = state_q == PASS2 ? carry_q : state_q == PASS1 && (op_q == OP_ADD ? cin_q : op_q == OP_SUB);
        carry_d = passing && !FLUSH ? ALU_SC_OUT : carry_q;
        byte_d = state_q == PASS1 && !FLUSH ? ALU_OUT : byte_q;
        result_d = state_q != PASS2 || FLUSH ? result_q : op_q == OP_RSH ? {byte_q, ALU_OUT} : {ALU_OUT, byte_q};
        cout_d = state_q == PASS2 && !FLUSH ? ALU_SC_OUT : cout_q;
        zero_d = result_d == 16'h0000;
    end
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            op_q <= 2'b00;
            a_q <= 16'h0000;
            b_q <= 16'h0000;
            cin_q <= 1'b0;
            carry_q <= 1'b0;
            byte_q <= 8'h00;
            result_q <= 16'h0000;
            cout_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            cin_q <= cin_d;
            carry_q <= carry_d;
            byte_q <= byte_d;
            result_q <= result_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
        end
    end
    assign BUSY = passing;
    assign DONE = state_q == FIN;
    assign RESULT = result_q;
    assign COUT = cout_q;
    assign ZERO16 = zero_q;
endmodule

// File: tb/tb_wide_alu_seq.sv
// tb_wide_alu_seq: directed checks of wide_alu_seq against a behavioural model of the shared 8-bit ALU.
module tb_wide_alu_seq;
    import wide_alu_pkg::*;
    logic CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, CIN = 1'b0, FLUSH = 1'b0;
    logic [1:0] OP = 2'b00;
    logic [15:0] A = 16'h0000, B = 16'h0000;
    logic BUSY, DONE, COUT, ZERO16, ALU_SC_IN, ALU_SC_OUT;
    logic [15:0] RESULT;
    logic [7:0] ALU_A, ALU_B, ALU_OUT;
    logic [3:0] ALU_OP;
    int total = 0, bad = 0;
    logic [15:0] last_res = 16'h0000;

    wide_alu_seq dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP), .A(A), .B(B), .CIN(CIN),
        .FLUSH(FLUSH), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT), .ZERO16(ZERO16),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_SC_IN(ALU_SC_IN),
        .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        {ALU_SC_OUT, ALU_OUT} = 9'h000;
        if (ALU_OP == KADD) {ALU_SC_OUT, ALU_OUT} = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'h00, ALU_SC_IN};
        else if (ALU_OP == KLSH) {ALU_SC_OUT, ALU_OUT} = {ALU_A, ALU_SC_IN};
        else if (ALU_OP == KRSH) {ALU_OUT, ALU_SC_OUT} = {ALU_SC_IN, ALU_A};
        else {ALU_SC_OUT, ALU_OUT} = {1'b0, ALU_A - ALU_B};
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] aluop_of(input logic [1:0] op);
        return op == OP_LSH ? KLSH : op == OP_RSH ? KRSH : KADD;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] er, input logic ec);
        logic [7:0] a1, a2, b1, b2;
        a1 = op == OP_RSH ? a[15:8] : a[7:0];
        a2 = op == OP_RSH ? a[7:0] : a[15:8];
        b1 = op == OP_ADD ? b[7:0] : op == OP_SUB ? ~b[7:0] : 8'h00;
        b2 = op == OP_ADD ? b[15:8] : op == OP_SUB ? ~b[15:8] : 8'h00;
        OP = op; A = a; B = b; CIN = cin; START = 1'b1;
        @(negedge CLK);
        START = 1'b0; OP = ~op; A = ~a; B = ~b; CIN = ~cin;
        chk("p1_busy", {15'h0, BUSY}, 16'h1);
        chk("p1_aluop", {12'h0, ALU_OP}, {12'h0, aluop_of(op)});
        chk("p1_alua", {8'h0, ALU_A}, {8'h0, a1});
        chk("p1_alub", {8'h0, ALU_B}, {8'h0, b1});
        chk("p1_hold", RESULT, last_res);
        @(negedge CLK);
        chk("p2_aluop", {12'h0, ALU_OP}, {12'h0, aluop_of(op)});
        chk("p2_alua", {8'h0, ALU_A}, {8'h0, a2});
        chk("p2_alub", {8'h0, ALU_B}, {8'h0, b2});
        chk("p2_hold", RESULT, last_res);
        @(negedge CLK);
        chk("fin_done", {14'h0, DONE, BUSY}, 16'h2);
        chk("fin_result", RESULT, er);
        chk("fin_cout", {15'h0, COUT}, {15'h0, ec});
        chk("fin_zero", {15'h0, ZERO16}, {15'h0, er == 16'h0000});
        chk("fin_alu_idle", {ALU_OP, ALU_A, ALU_B[3:0]}, {KADD, 12'h000});
        last_res = er;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_busy_done", {14'h0, BUSY, DONE}, 16'h0);
        chk("rst_result", RESULT, 16'h0000);
        chk("rst_cout_zero", {14'h0, COUT, ZERO16}, 16'h1);
        chk("rst_alu", {ALU_OP, ALU_A, ALU_B[3:0]}, {KADD, 12'h000});
        @(negedge CLK);
        RESET_N = 1'b1;
        run_op(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op(OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0);
        run_op(OP_SUB, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1);
        run_op(OP_LSH, 16'h80F0, 16'h1234, 1'b1, 16'h01E0, 1'b1);
        run_op(OP_RSH, 16'h0101, 16'h5678, 1'b1, 16'h0080, 1'b1);
        run_op(OP_ADD, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0);
        // START held high across two operations with operands changing mid-flight
        OP = OP_ADD; A = 16'h0001; B = 16'h0002; CIN = 1'b0; START = 1'b1;
        @(negedge CLK);
        chk("b2b_p1_busy", {15'h0, BUSY}, 16'h1);
        A = 16'h7777;
        @(negedge CLK);
        chk("b2b_p2_busy", {14'h0, BUSY, DONE}, 16'h2);
        A = 16'h0003;
        @(negedge CLK);
        chk("b2b_fin1_done", {15'h0, DONE}, 16'h1);
        chk("b2b_fin1_result", RESULT, 16'h0003);
        A = 16'h0005; B = 16'h0006;
        @(negedge CLK);
        chk("b2b_nobubble", {14'h0, BUSY, DONE}, 16'h2);
        chk("b2b_hold", RESULT, 16'h0003);
        A = 16'h0009;
        @(negedge CLK);
        @(negedge CLK);
        chk("b2b_fin2_done", {15'h0, DONE}, 16'h1);
        chk("b2b_fin2_result", RESULT, 16'h000B);
        chk("b2b_fin2_cz", {14'h0, COUT, ZERO16}, 16'h0);
        START = 1'b0;
        @(negedge CLK);
        chk("b2b_idle", {14'h0, BUSY, DONE}, 16'h0);
        // FLUSH during PASS2 with a competing START
        OP = OP_ADD; A = 16'h0001; B = 16'h0001; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        FLUSH = 1'b1; START = 1'b1;
        @(negedge CLK);
        chk("flush_state", {14'h0, BUSY, DONE}, 16'h0);
        chk("flush_result", RESULT, 16'h000B);
        chk("flush_cz", {14'h0, COUT, ZERO16}, 16'h0);
        FLUSH = 1'b0; START = 1'b0;
        @(negedge CLK);
        chk("flush_nodone", {14'h0, BUSY, DONE}, 16'h0);
        // reset asserted mid-operation in PASS1
        OP = OP_LSH; A = 16'h0001; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("rstmid_busy", {15'h0, BUSY}, 16'h1);
        RESET_N = 1'b0;
        #1;
        chk("rstmid_state", {14'h0, BUSY, DONE}, 16'h0);
        chk("rstmid_result", RESULT, 16'h0000);
        chk("rstmid_cz", {14'h0, COUT, ZERO16}, 16'h1);
        @(negedge CLK);
        RESET_N = 1'b1;
        last_res = 16'h0000;
        @(negedge CLK);
        chk("rstmid_nodone1", {14'h0, BUSY, DONE}, 16'h0);
        @(negedge CLK);
        chk("rstmid_nodone2", {14'h0, BUSY, DONE}, 16'h0);
        run_op(OP_ADD, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wide_alu_seq.md
WIDE_ALU_SEQ -- requirements
Module: wide_alu_seq

Interface
REQ-001 The block SHALL have ports: CLK  in  1  sole clock, rising-edge.
REQ-002 The block SHALL have ports: RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-003 The block SHALL have ports: START  in  1  request strobe; OP  in  2  00=ADD16, 01=SUB16, 10=LSH16, 11=RSH16.
REQ-004 The block SHALL have ports: A  in  16; B  in  16; CIN  in  1  carry-in, ADD16 only.
REQ-005 The block SHALL have ports: FLUSH  in  1  synchronous abort.
REQ-006 The block SHALL have ports: BUSY  out  1; DONE  out  1; RESULT  out  16; COUT  out  1; ZERO16  out  1.
REQ-007 The block SHALL have ALU-side ports: ALU_A  out  8; ALU_B  out  8; ALU_OP  out  4, codes from the definitions package; ALU_SC_IN  out  1; ALU_OUT  in  8; ALU_SC_OUT  in  1.

Function
REQ-008 The block SHALL sequence one 16-bit operation as two 8-bit passes through the shared combinational ALU, with a 4-state FSM: IDLE, PASS1, PASS2, FIN.
REQ-009 START SHALL be accepted only in IDLE or FIN; it latches OP, A, B and CIN, and the next state is PASS1.
REQ-010 START in PASS1 or PASS2 SHALL be ignored. A/B/OP/CIN changes after acceptance SHALL have no effect.
REQ-011 Transitions SHALL be: PASS1->PASS2 and PASS2->FIN unconditionally; FIN->IDLE unless START is present.
REQ-012 At each pass-state clock edge, the block SHALL capture ALU_OUT into the pass's result byte and ALU_SC_OUT into an internal carry register.
REQ-013 ADD16 SHALL use ALU_OP=KADD. PASS1: low bytes, ALU_SC_IN=CIN. PASS2: high bytes, ALU_SC_IN=captured carry.
REQ-014 SUB16 SHALL use ALU_OP=KADD with ALU_B=~B byte. PASS1 ALU_SC_IN=1; PASS2 ALU_SC_IN=captured carry. The ALU KSUB opcode SHALL NOT be used.
REQ-015 LSH16 SHALL use ALU_OP=KLSH. PASS1: low byte, ALU_SC_IN=0. PASS2: high byte, ALU_SC_IN=captured carry.
REQ-016 RSH16 SHALL use ALU_OP=KRSH. PASS1: high byte, ALU_SC_IN=0. PASS2: low byte, ALU_SC_IN=captured carry. For LSH16 and RSH16, ALU_B SHALL be 0.
REQ-017 COUT SHALL equal the PASS2 ALU_SC_OUT: ADD16 carry; SUB16 1=no borrow; LSH16 A[15]; RSH16 A[0].
REQ-018 ZERO16 SHALL be 1 when the final 16-bit RESULT==0, registered with RESULT.
REQ-019 DONE SHALL be high for exactly the FIN cycle, i.e. the 3rd cycle after the accepting edge. BUSY SHALL be high in PASS1 and PASS2 only.
REQ-020 RESULT, COUT and ZERO16 SHALL hold from FIN until the next FIN; they SHALL NOT change during PASS1/PASS2 of a following operation.
REQ-021 Back-to-back: START in FIN SHALL give PASS1 next, with no IDLE bubble.
REQ-022 FLUSH SHALL force IDLE on the next edge from any state; the abort SHALL produce no DONE and leave RESULT/COUT/ZERO16 unchanged. FLUSH SHALL win over a simultaneous START.
REQ-023 In IDLE and FIN, ALU_OP SHALL be KADD and ALU_A, ALU_B, ALU_SC_IN SHALL be 0.

Reset
REQ-024 RESET_N low SHALL immediately force IDLE, with BUSY=0, DONE=0, RESULT=0, COUT=0, ZERO16=1, carry register=0, and latched operands 0.
REQ-025 Reset mid-operation SHALL discard the operation; no DONE SHALL follow reset release.
REQ-026 The first START SHALL be accepted on the first rising edge with RESET_N high.

Verification
REQ-027 ADD16 A=0x00FF B=0x0001 CIN=0 -> DONE 3 cycles after accept; RESULT=0x0100, COUT=0, ZERO16=0.
REQ-028 ADD16 A=0xFFFF B=0x0001 CIN=0 -> RESULT=0x0000, COUT=1, ZERO16=1. SUB16 A=0x0000 B=0x0001 -> RESULT=0xFFFF, COUT=0. SUB16 A=0x0100 B=0x0001 -> RESULT=0x00FF, COUT=1.
REQ-029 LSH16 A=0x80F0 -> RESULT=0x01E0, COUT=1. RSH16 A=0x0101 -> RESULT=0x0080, COUT=1. In every pass, check ALU_OP and byte order.
REQ-030 START held high continuously with changing operands -> one accept per FIN; intermediate START pulses during BUSY ignored; results match the operands latched at each accept.
REQ-031 FLUSH in PASS2, and separately RESET_N low in PASS1 -> no DONE; RESULT keeps its prior value (FLUSH) or becomes 0x0000 with ZERO16=1 (reset).
